// File: rtl/alu_pkg.sv
// Shared types for the RPN ALU controller: opcodes, FSM states and the
// bit positions inside the {N,Z,C,V} status word.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_OR  = 2'd2,
    OP_AND = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    ST_WAIT_A      = 2'd0,
    ST_WAIT_B      = 2'd1,
    ST_WAIT_OP     = 2'd2,
    ST_SHOW_RESULT = 2'd3
  } state_e;

  localparam int STAT_N = 3;
  localparam int STAT_Z = 2;
  localparam int STAT_C = 1;
  localparam int STAT_V = 0;

  // The state encoding is dense, so the LED pattern is simply a shifted one.
  function automatic logic [3:0] state_onehot(input state_e s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 4-function ALU: add/sub with carry/borrow and signed
// overflow, bitwise or/and with C and V forced low.
module alu_core
  import alu_pkg::*;
#(
  parameter int C_WIDTH = 8
) (
  input  logic [C_WIDTH-1:0] a_in,
  input  logic [C_WIDTH-1:0] b_in,
  input  opcode_e            op_in,
  output logic [C_WIDTH-1:0] result_out,
  output logic [3:0]         status_out
);

  logic [C_WIDTH:0]   wide;
  logic [C_WIDTH-1:0] res;
  logic               carry;
  logic               ovf;

  always_comb begin
    wide  = '0;
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_in)
      OP_ADD: begin
        wide  = {1'b0, a_in} + {1'b0, b_in};
        res   = wide[C_WIDTH-1:0];
        carry = wide[C_WIDTH];
        ovf   = (a_in[C_WIDTH-1] == b_in[C_WIDTH-1]) && (res[C_WIDTH-1] != a_in[C_WIDTH-1]);
      end
      OP_SUB: begin
        // The extra MSB of the difference is the borrow out.
        wide  = {1'b0, a_in} - {1'b0, b_in};
        res   = wide[C_WIDTH-1:0];
        carry = wide[C_WIDTH];
        ovf   = (a_in[C_WIDTH-1] != b_in[C_WIDTH-1]) && (res[C_WIDTH-1] != a_in[C_WIDTH-1]);
      end
      OP_OR:   res = a_in | b_in;
      OP_AND:  res = a_in & b_in;
      default: res = '0;
    endcase
  end

  always_comb begin
    status_out         = '0;
    status_out[STAT_N] = res[C_WIDTH-1];
    status_out[STAT_Z] = (res == '0);
    status_out[STAT_C] = carry;
    status_out[STAT_V] = ovf;
  end

  assign result_out = res;

endmodule

// File: rtl/alu_rpn_ctrl.sv
// RPN sequencing controller: collects A, B and an opcode one enter at a
// time, latches the ALU result/flags and drives display value and LEDs.
module alu_rpn_ctrl
  import alu_pkg::*;
#(
  parameter int C_WIDTH = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [C_WIDTH-1:0] data_in,
  input  logic [1:0]         op_in,
  input  logic               enter,
  input  logic               undo,
  input  logic               chain,
  output logic [C_WIDTH-1:0] disp_value,
  output logic [C_WIDTH-1:0] result,
  output logic [3:0]         status,
  output logic [3:0]         state_leds,
  output logic               result_valid
);

  state_e             state_q,  state_d;
  logic [C_WIDTH-1:0] a_q,      a_d;
  logic [C_WIDTH-1:0] b_q,      b_d;
  opcode_e            op_q,     op_d;
  logic [C_WIDTH-1:0] result_q, result_d;
  logic [3:0]         status_q, status_d;

  opcode_e            alu_op;
  logic [C_WIDTH-1:0] alu_result;
  logic [3:0]         alu_status;

  // Outside WAIT_OP the ALU idles on the last committed opcode; its output
  // is only captured on the WAIT_OP enter, where the live op_in is used.
  assign alu_op = (state_q == ST_WAIT_OP) ? opcode_e'(op_in) : op_q;

  alu_core #(
    .C_WIDTH(C_WIDTH)
  ) u_alu_core (
    .a_in      (a_q),
    .b_in      (b_q),
    .op_in     (alu_op),
    .result_out(alu_result),
    .status_out(alu_status)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    status_d = status_q;
    if (undo) begin
      case (state_q)
        ST_WAIT_B:      state_d = ST_WAIT_A;
        ST_WAIT_OP:     state_d = ST_WAIT_B;
        ST_SHOW_RESULT: state_d = ST_WAIT_OP;
        default:        state_d = state_q;
      endcase
    end else if (enter) begin
      case (state_q)
        ST_WAIT_A: begin
          a_d     = data_in;
          state_d = ST_WAIT_B;
        end
        ST_WAIT_B: begin
          b_d     = data_in;
          state_d = ST_WAIT_OP;
        end
        ST_WAIT_OP: begin
          op_d     = opcode_e'(op_in);
          result_d = alu_result;
          status_d = alu_status;
          state_d  = ST_SHOW_RESULT;
        end
        default: begin
          a_d      = '0;
          b_d      = '0;
          op_d     = OP_ADD;
          result_d = '0;
          status_d = '0;
          state_d  = ST_WAIT_A;
        end
      endcase
    end else if (chain && (state_q == ST_SHOW_RESULT)) begin
      a_d     = result_q;
      state_d = ST_WAIT_B;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= ST_WAIT_A;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    disp_value = data_in;
    case (state_q)
      ST_WAIT_OP:     disp_value = {{(C_WIDTH-2){1'b0}}, op_in};
      ST_SHOW_RESULT: disp_value = result_q;
      default:        disp_value = data_in;
    endcase
  end

  assign result       = result_q;
  assign status       = status_q;
  assign state_leds   = state_onehot(state_q);
  assign result_valid = (state_q == ST_SHOW_RESULT);

endmodule

// File: tb/tb_alu_rpn_ctrl.sv
// Bench for alu_rpn_ctrl: scenario tasks drive pulses, a result monitor
// pops expected {result,status} from a scoreboard on each result_valid rise.
module tb_alu_rpn_ctrl;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] data_in = '0;
  logic [1:0] op_in = '0;
  logic       enter = 1'b0;
  logic       undo = 1'b0;
  logic       chain = 1'b0;
  logic [7:0] disp_value;
  logic [7:0] result;
  logic [3:0] status;
  logic [3:0] state_leds;
  logic       result_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] res;
    logic [3:0] stat;
    string      name;
  } exp_t;
  exp_t sb_q[$];

  alu_rpn_ctrl #(.C_WIDTH(8)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .data_in     (data_in),
    .op_in       (op_in),
    .enter       (enter),
    .undo        (undo),
    .chain       (chain),
    .disp_value  (disp_value),
    .result      (result),
    .status      (status),
    .state_leds  (state_leds),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  // Independent reference: integer arithmetic, signed range test for V.
  function automatic logic [11:0] model(input int a, input int b, input int op);
    int r, c, v, sa, sbv, sr;
    logic [7:0] rr;
    sa  = (a > 127) ? a - 256 : a;
    sbv = (b > 127) ? b - 256 : b;
    r = 0; c = 0; v = 0; sr = 0;
    case (op)
      0: begin r = a + b; c = (r > 255) ? 1 : 0; sr = sa + sbv; end
      1: begin r = a - b; c = (a < b) ? 1 : 0;   sr = sa - sbv; end
      2: r = a | b;
      default: r = a & b;
    endcase
    if (op < 2) v = (sr > 127 || sr < -128) ? 1 : 0;
    rr = r[7:0];
    return {rr, (rr > 8'd127), (rr == 8'd0), (c != 0), (v != 0)};
  endfunction

  task automatic push_exp(input int a, input int b, input int op, input string name);
    logic [11:0] m;
    exp_t e;
    m = model(a, b, op);
    e.res  = m[11:4];
    e.stat = m[3:0];
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic e, input logic u, input logic c,
                       input logic [7:0] d, input logic [1:0] o);
    @(negedge clk);
    data_in = d; op_in = o; enter = e; undo = u; chain = c;
    @(negedge clk);
    enter = 1'b0; undo = 1'b0; chain = 1'b0;
  endtask

  // Scoreboard consumer
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    if (result_valid && !rv_prev) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_result: result_valid rose with empty scoreboard, result=%h", result);
      end else begin
        e = sb_q.pop_front();
        n_checks++;
        if (result !== e.res) begin
          n_fail++;
          $display("FAIL %s result: got %h expected %h", e.name, result, e.res);
        end
        n_checks++;
        if (status !== e.stat) begin
          n_fail++;
          $display("FAIL %s status: got %b expected %b", e.name, status, e.stat);
        end
        n_checks++;
        if (disp_value !== e.res) begin
          n_fail++;
          $display("FAIL %s disp_value: got %h expected %h", e.name, disp_value, e.res);
        end
        $display("txn %s: result=%h status=%b", e.name, result, status);
      end
    end
    rv_prev <= result_valid;
  end

  task automatic test_reset();
    n_checks++;
    if (state_leds !== 4'b0001 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: leds=%b rv=%b expected 0001/0", state_leds, result_valid);
    end
    n_checks++;
    if (result !== 8'h00 || status !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_regs: result=%h status=%b expected 00/0000", result, status);
    end
    data_in = 8'h5A;
    #1;
    n_checks++;
    if (disp_value !== 8'h5A) begin
      n_fail++;
      $display("FAIL reset_disp: got %h expected 5a", disp_value);
    end
    $display("txn reset: leds=%b", state_leds);
  endtask

  task automatic test_add_overflow();
    drive(1, 0, 0, 8'h7F, 2'd0);
    drive(1, 0, 0, 8'h01, 2'd0);
    push_exp(8'h7F, 8'h01, 0, "add_7f_01");
    drive(1, 0, 0, 8'h00, 2'd0);
    n_checks++;
    if (state_leds !== 4'b1000 || result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL add_leds: leds=%b rv=%b expected 1000/1", state_leds, result_valid);
    end
    drive(1, 0, 0, 8'h00, 2'd0);
    n_checks++;
    if (result !== 8'h00 || status !== 4'h0 || state_leds !== 4'b0001) begin
      n_fail++;
      $display("FAIL clear_after_show: result=%h status=%b leds=%b expected 00/0000/0001",
               result, status, state_leds);
    end
  endtask

  task automatic test_sub();
    drive(1, 0, 0, 8'h05, 2'd1);
    drive(1, 0, 0, 8'h05, 2'd1);
    push_exp(8'h05, 8'h05, 1, "sub_05_05");
    drive(1, 0, 0, 8'h00, 2'd1);
    drive(1, 0, 0, 8'h00, 2'd1);
    drive(1, 0, 0, 8'h03, 2'd1);
    drive(1, 0, 0, 8'h05, 2'd1);
    push_exp(8'h03, 8'h05, 1, "sub_03_05");
    drive(1, 0, 0, 8'h00, 2'd1);
    // result must hold while inputs wander
    data_in = 8'hAA; op_in = 2'd3;
    repeat (2) @(negedge clk);
    n_checks++;
    if (result !== 8'hFE || status !== 4'b1010) begin
      n_fail++;
      $display("FAIL sub_hold: result=%h status=%b expected fe/1010", result, status);
    end
    drive(1, 0, 0, 8'h00, 2'd0);
  endtask

  task automatic test_or_chain();
    drive(1, 0, 0, 8'hF0, 2'd2);
    drive(1, 0, 0, 8'h0F, 2'd2);
    push_exp(8'hF0, 8'h0F, 2, "or_f0_0f");
    drive(1, 0, 0, 8'h00, 2'd2);
    drive(0, 0, 1, 8'h00, 2'd2);
    n_checks++;
    if (state_leds !== 4'b0010 || dut.a_q !== 8'hFF) begin
      n_fail++;
      $display("FAIL chain_state: leds=%b a=%h expected 0010/ff", state_leds, dut.a_q);
    end
    drive(1, 0, 0, 8'h0F, 2'd3);
    push_exp(8'hFF, 8'h0F, 3, "and_chain_0f");
    drive(1, 0, 0, 8'h00, 2'd3);
    drive(1, 0, 0, 8'h00, 2'd0);
    drive(0, 0, 1, 8'h00, 2'd0);
    n_checks++;
    if (state_leds !== 4'b0001) begin
      n_fail++;
      $display("FAIL chain_ignored: leds=%b expected 0001", state_leds);
    end
  endtask

  task automatic test_undo();
    drive(1, 0, 0, 8'h01, 2'd0);
    drive(1, 0, 0, 8'h09, 2'd0);
    drive(0, 1, 0, 8'h00, 2'd0);
    n_checks++;
    if (state_leds !== 4'b0010) begin
      n_fail++;
      $display("FAIL undo_wait_op: leds=%b expected 0010", state_leds);
    end
    drive(1, 0, 0, 8'h02, 2'd2);
    n_checks++;
    if (state_leds !== 4'b0100 || disp_value !== 8'h02) begin
      n_fail++;
      $display("FAIL wait_op_disp: leds=%b disp=%h expected 0100/02", state_leds, disp_value);
    end
    push_exp(8'h01, 8'h02, 0, "undo_add_01_02");
    drive(1, 0, 0, 8'h00, 2'd0);
    drive(0, 1, 0, 8'h00, 2'd0);
    n_checks++;
    if (state_leds !== 4'b0100 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL undo_show: leds=%b rv=%b expected 0100/0", state_leds, result_valid);
    end
    push_exp(8'h01, 8'h02, 3, "undo_and_01_02");
    drive(1, 0, 0, 8'h00, 2'd3);
    drive(1, 0, 0, 8'h00, 2'd0);
    drive(0, 1, 0, 8'h00, 2'd0);
    n_checks++;
    if (state_leds !== 4'b0001) begin
      n_fail++;
      $display("FAIL undo_wait_a: leds=%b expected 0001", state_leds);
    end
  endtask

  task automatic test_enter_undo_same();
    drive(1, 0, 0, 8'h11, 2'd0);
    drive(1, 0, 0, 8'h22, 2'd0);
    drive(0, 1, 0, 8'h00, 2'd0);
    drive(1, 1, 0, 8'h99, 2'd0);
    n_checks++;
    if (state_leds !== 4'b0001 || dut.b_q !== 8'h22) begin
      n_fail++;
      $display("FAIL enter_undo_prio: leds=%b b=%h expected 0001/22", state_leds, dut.b_q);
    end
    $display("txn enter_undo: leds=%b b=%h", state_leds, dut.b_q);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [7:0] a, b;
      logic [1:0] o;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      o = 2'(i % 4);
      drive(1, 0, 0, a, o);
      drive(1, 0, 0, b, o);
      push_exp(int'(a), int'(b), int'(o), $sformatf("b2b_%0d", i));
      drive(1, 0, 0, 8'h00, o);
      drive(1, 0, 0, 8'h00, 2'd0);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 8'h40, 2'd0);
    drive(1, 0, 0, 8'h41, 2'd0);
    push_exp(8'h40, 8'h41, 0, "pre_reset_add");
    drive(1, 0, 0, 8'h00, 2'd0);
    drive(0, 0, 1, 8'h00, 2'd0);
    drive(1, 0, 0, 8'h03, 2'd1);
    data_in = 8'h3C;
    @(posedge clk);
    #2 resetN = 1'b0;
    #1;
    n_checks++;
    if (state_leds !== 4'b0001 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_state: leds=%b rv=%b expected 0001/0", state_leds, result_valid);
    end
    n_checks++;
    if (result !== 8'h00 || status !== 4'h0 || dut.a_q !== 8'h00 || dut.b_q !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset_regs: result=%h status=%b a=%h b=%h expected all 0",
               result, status, dut.a_q, dut.b_q);
    end
    n_checks++;
    if (disp_value !== 8'h3C) begin
      n_fail++;
      $display("FAIL async_reset_disp: got %h expected 3c", disp_value);
    end
    $display("txn async_reset: leds=%b result=%h", state_leds, result);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    resetN = 1'b1;
    @(negedge clk);
    test_reset();
    test_add_overflow();
    test_sub();
    test_or_chain();
    test_undo();
    test_enter_undo_same();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected results never produced", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
